npn_tt_sweeper: RTL

Sequential stimulus/capture stage that sits directly upstream of a 4-input exact-synthesis AIG (inputs x0..x3, output y0). It accepts one NPN transform request, sweeps all 16 minterms through the transform into the AIG, and captures its output into a 16-bit truth table. It then compares the table against an expected value and returns the result over a valid/ready handshake.

---
 rtl/npn_pkg.sv | 33 +++
 rtl/npn_input_xform.sv | 22 ++
 rtl/npn_tt_sweeper.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/npn_pkg.sv
// Shared definitions for the NPN truth-table sweeper and its companion checkers.
//   N_IN / TT_W   : AIG input count and truth-table width
//   state_e       : sweeper FSM states
//   IDENTITY_PERM : perm_sel value that routes minterm bit i to x_out[i]
//   is_perm()     : true when the four 2-bit selects name every input exactly once
package npn_pkg;

  localparam int unsigned N_IN   = 4;
  localparam int unsigned TT_W   = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned PERM_W = N_IN * SEL_W;

  localparam logic [PERM_W-1:0] IDENTITY_PERM = 8'b11_10_01_00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Mark each selected source; a permutation covers all four.
  function automatic logic is_perm(input logic [PERM_W-1:0] perm_sel);
    logic [N_IN-1:0] seen;
    seen = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      seen[perm_sel[SEL_W*i +: SEL_W]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage

// File: rtl/npn_input_xform.sv
// Combinational NPN input transform: minterm m -> AIG input vector.
//   m        : minterm index (bit j = minterm variable j)
//   neg      : per-output negation mask
//   perm_sel : perm_sel[2i+1:2i] selects the minterm bit routed to x_out[i]
//   x_out    : transformed AIG inputs
module npn_input_xform
  import npn_pkg::*;
(
  input  logic [N_IN-1:0]   m,
  input  logic [N_IN-1:0]   neg,
  input  logic [PERM_W-1:0] perm_sel,
  output logic [N_IN-1:0]   x_out
);

  always_comb begin
    x_out = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      x_out[i] = m[perm_sel[SEL_W*i +: SEL_W]] ^ neg[i];
    end
  end

endmodule

// File: rtl/npn_tt_sweeper.sv
// Sweeps all 16 minterms of one NPN request through a 4-input AIG and
// captures its output into a truth table, then reports it over valid/ready.
//   clk, rst               : clock, synchronous active-high reset
//   start_valid/ready      : request handshake (ready only in IDLE)
//   neg, perm_sel, out_neg : NPN transform, captured on accept
//   expect_tt              : reference table, captured on accept
//   x_out / y_in           : AIG stimulus / AIG response
//   res_valid/ready        : result handshake
//   tt, match, perm_err    : captured table, tt==expect_tt, bad permutation
//   busy                   : FSM not in IDLE
module npn_tt_sweeper
  import npn_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [N_IN-1:0]   neg,
  input  logic [PERM_W-1:0] perm_sel,
  input  logic              out_neg,
  input  logic [TT_W-1:0]   expect_tt,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TT_W-1:0]   tt,
  output logic              match,
  output logic              perm_err,
  output logic              busy
);

  localparam int unsigned CNT_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam bit          HAS_WAIT = (SETTLE != 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TT_W - 1);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   neg_q, neg_d;
  logic [PERM_W-1:0] perm_q, perm_d;
  logic              out_neg_q, out_neg_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   tt_d;
  logic              match_d, perm_err_d;
  logic [N_IN-1:0]   x_out_d;
  logic              start_ready_d, busy_d, res_valid_d;

  logic              accept_c;
  logic [N_IN-1:0]   xf_m_c, xf_neg_c, xf_x_c;
  logic [PERM_W-1:0] xf_perm_c;

  // start_ready is low for the first cycle after reset, so gate on it too.
  assign accept_c = (state_q == IDLE) && start_valid && start_ready;

  // On accept the transform uses the live request; during the sweep, the captured one.
  assign xf_m_c    = accept_c ? '0        : N_IN'(idx_q + IDX_W'(1));
  assign xf_neg_c  = accept_c ? neg       : neg_q;
  assign xf_perm_c = accept_c ? perm_sel  : perm_q;

  npn_input_xform u_xform (
    .m        (xf_m_c),
    .neg      (xf_neg_c),
    .perm_sel (xf_perm_c),
    .x_out    (xf_x_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept_c) state_d = HAS_WAIT ? WAIT : SWEEP;
      WAIT:  if (cnt_q == CNT_W'(1)) state_d = SWEEP;
      SWEEP: begin
        if (idx_q == IDX_LAST) state_d = DONE;
        else                   state_d = HAS_WAIT ? WAIT : SWEEP;
      end
      DONE:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    perm_d     = perm_q;
    out_neg_d  = out_neg_q;
    exp_d      = exp_q;
    tt_d       = tt;
    match_d    = match;
    perm_err_d = perm_err;
    x_out_d    = x_out;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          neg_d      = neg;
          perm_d     = perm_sel;
          out_neg_d  = out_neg;
          exp_d      = expect_tt;
          idx_d      = '0;
          cnt_d      = CNT_W'(SETTLE);
          tt_d       = '0;
          match_d    = 1'b0;
          perm_err_d = 1'b0;
          x_out_d    = xf_x_c;
        end
      end
      WAIT: cnt_d = cnt_q - CNT_W'(1);
      SWEEP: begin
        tt_d[idx_q] = y_in ^ out_neg_q;
        if (idx_q == IDX_LAST) begin
          // Judge the completed table including the bit sampled this edge.
          match_d    = (tt_d == exp_q);
          perm_err_d = ~is_perm(perm_q);
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = CNT_W'(SETTLE);
          x_out_d = xf_x_c;
        end
      end
      default: ;
    endcase

    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    res_valid_d   = (state_d == DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= '0;
      perm_q      <= '0;
      out_neg_q   <= 1'b0;
      exp_q       <= '0;
      tt          <= '0;
      match       <= 1'b0;
      perm_err    <= 1'b0;
      x_out       <= '0;
      start_ready <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      perm_q      <= perm_d;
      out_neg_q   <= out_neg_d;
      exp_q       <= exp_d;
      tt          <= tt_d;
      match       <= match_d;
      perm_err    <= perm_err_d;
      x_out       <= x_out_d;
      start_ready <= start_ready_d;
      busy        <= busy_d;
      res_valid   <= res_valid_d;
    end
  end

endmodule
